// File: rtl/feature_linebuffer.sv
// Sliding-window line buffer for a feature stream.
// Builds a TAPS-long window (index 0 oldest) from accepted samples and
// presents it to a downstream inner-product stage every STRIDE samples once
// primed. Backpressure freezes the window until the downstream consumes it.
module feature_linebuffer #(
    parameter int WIDTH  = 32,
    parameter int TAPS   = 41,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] xarray [0:TAPS-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             primed
);

    localparam int CW = $clog2(TAPS + 1);
    localparam logic [CW-1:0] FILL_FULL   = CW'(TAPS);
    localparam logic [CW-1:0] FILL_LAST   = CW'(TAPS - 1);
    localparam logic [CW-1:0] STRIDE_LAST = CW'(STRIDE - 1);

    logic [WIDTH-1:0] win_reg [0:TAPS-1];
    logic [CW-1:0]    fill_cnt_reg;
    logic [CW-1:0]    stride_cnt_reg;
    logic             out_valid_reg;
    logic             primed_reg;
    logic             accept;
    logic             emit;

    // A presented but unconsumed window blocks further input.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // The priming accept emits the first window; afterwards every STRIDE-th accept emits.
    assign emit = accept &&
                  ((fill_cnt_reg == FILL_LAST) ||
                   (primed_reg && (stride_cnt_reg == STRIDE_LAST)));

    assign out_valid = out_valid_reg;
    assign primed    = primed_reg;

    // Window shift register: each tap takes its younger neighbour, the newest tap takes in_data.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi == TAPS - 1) begin : g_newest
                // Newest tap loads the incoming sample.
                always_ff @(posedge clk) begin
                    if (rst || clear) begin
                        win_reg[gi] <= '0;
                    end else if (accept) begin
                        win_reg[gi] <= in_data;
                    end
                end
            end else begin : g_older
                // Older taps shift toward index 0.
                always_ff @(posedge clk) begin
                    if (rst || clear) begin
                        win_reg[gi] <= '0;
                    end else if (accept) begin
                        win_reg[gi] <= win_reg[gi+1];
                    end
                end
            end
            assign xarray[gi] = win_reg[gi];
        end
    endgenerate

    // Fill counter saturating at TAPS; primed mirrors the saturated state as a register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fill_cnt_reg <= '0;
            primed_reg   <= 1'b0;
        end else if (accept && (fill_cnt_reg != FILL_FULL)) begin
            fill_cnt_reg <= fill_cnt_reg + 1'b1;
            primed_reg   <= (fill_cnt_reg == FILL_LAST);
        end
    end

    // Stride counter: restarts on every emitted window, advances on other primed accepts.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            stride_cnt_reg <= '0;
        end else if (emit) begin
            stride_cnt_reg <= '0;
        end else if (accept && primed_reg) begin
            stride_cnt_reg <= stride_cnt_reg + 1'b1;
        end
    end

    // Output handshake: emit sets valid (even while consuming), a consume without emit clears it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid_reg <= 1'b0;
        end else if (emit) begin
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_feature_linebuffer.sv
// Self-checking bench for feature_linebuffer (TAPS=41).
// A behavioural model plus a window scoreboard check the STRIDE=1 instance
// every cycle; table rows and hand-written sequences cover the corner cases.
// A second instance with STRIDE=4 and out_ready tied high checks striding.
module tb_feature_linebuffer;

    localparam int W = 32;
    localparam int T = 41;
    localparam int S = 1;

    typedef logic [T*W-1:0] flat_t;

    typedef struct {
        bit         v;
        logic [W-1:0] d;
        bit         ordy;
        bit         ir;
        bit         ov;
        logic [W-1:0] x0;
        logic [W-1:0] xl;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_ready4 = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, primed;
    logic         in_ready4, out_valid4, primed4;
    logic [W-1:0] xarray  [0:T-1];
    logic [W-1:0] xarray4 [0:T-1];

    feature_linebuffer #(.WIDTH(W), .TAPS(T), .STRIDE(S)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .xarray(xarray), .out_valid(out_valid), .out_ready(out_ready),
        .primed(primed)
    );

    feature_linebuffer #(.WIDTH(W), .TAPS(T), .STRIDE(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .xarray(xarray4), .out_valid(out_valid4), .out_ready(out_ready4),
        .primed(primed4)
    );

    // Model state for the STRIDE=1 instance
    logic [W-1:0] m_win [0:T-1];
    int           m_fill = 0;
    int           m_stride = 0;
    bit           m_ov = 1'b0;
    bit           m_acc = 1'b0;
    bit           last_ir = 1'b0;
    flat_t        win_q [$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic flat_t pack_dut();
        flat_t f;
        for (int k = 0; k < T; k++) f[k*W +: W] = xarray[k];
        return f;
    endfunction

    function automatic flat_t pack_model();
        flat_t f;
        for (int k = 0; k < T; k++) f[k*W +: W] = m_win[k];
        return f;
    endfunction

    function automatic int diff_taps();
        int n = 0;
        for (int k = 0; k < T; k++) if (xarray[k] !== m_win[k]) n++;
        return n;
    endfunction

    function automatic int nonzero_taps();
        int n = 0;
        for (int k = 0; k < T; k++) if (xarray[k] !== '0) n++;
        return n;
    endfunction

    // One clock cycle: drive inputs, advance the model, then check after the edge.
    task automatic step(input bit r, input bit c, input bit v, input logic [W-1:0] d, input bit ordy);
        bit m_ir, consumed, emit;
        rst = r; clear = c; in_valid = v; in_data = d; out_ready = ordy;
        m_ir = !m_ov || ordy;
        #1;
        last_ir = in_ready;
        if (!r) chk("in_ready", in_ready, m_ir);
        m_acc = v && m_ir && !r && !c;
        if (r || c) begin
            m_fill = 0; m_stride = 0; m_ov = 1'b0;
            for (int k = 0; k < T; k++) m_win[k] = '0;
            win_q.delete();
        end else begin
            consumed = m_ov && ordy;
            emit = m_acc && ((m_fill == T-1) || (m_fill == T && m_stride == S-1));
            if (m_acc) begin
                if (m_fill == T) m_stride = emit ? 0 : m_stride + 1;
                else m_stride = 0;
                for (int k = 0; k < T-1; k++) m_win[k] = m_win[k+1];
                m_win[T-1] = d;
                if (m_fill < T) m_fill++;
            end
            if (emit) m_ov = 1'b1;
            else if (ordy) m_ov = 1'b0;
            if (consumed && win_q.size() > 0) void'(win_q.pop_front());
            if (emit) win_q.push_back(pack_model());
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("primed", primed, m_fill == T);
        chk("xarray_diff_taps", diff_taps(), 0);
        if (out_valid === 1'b1)
            chk("sb_window", (win_q.size() > 0) && (win_q[0] === pack_dut()), 1);
    endtask

    vec_t tbl [9];

    initial begin
        for (int k = 0; k < T; k++) m_win[k] = '0;

        // Stall for 5 cycles with window 1..41 presented, then slide to 2..42 and 3..43.
        for (int i = 0; i < 5; i++) tbl[i] = '{1, 42, 0, 0, 1, 1, 41};
        tbl[5] = '{1, 42, 1, 1, 1, 2, 42};
        tbl[6] = '{1, 43, 1, 1, 1, 3, 43};
        tbl[7] = '{0, 0,  1, 1, 0, 3, 43};
        tbl[8] = '{0, 0,  0, 1, 0, 3, 43};

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 5, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_primed", primed, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_zero_taps", nonzero_taps(), 0);

        // Prime with 1..41
        for (int i = 1; i <= T; i++) begin
            step(0, 0, 1, i, 1);
            chk("prime_valid", out_valid, i == T);
        end
        chk("prime_x0", xarray[0], 1);
        chk("prime_x40", xarray[T-1], 41);

        // Stall and slide table
        for (int i = 0; i < 9; i++) begin
            step(0, 0, tbl[i].v, tbl[i].d, tbl[i].ordy);
            chk("tbl_in_ready", last_ir, tbl[i].ir);
            chk("tbl_out_valid", out_valid, tbl[i].ov);
            chk("tbl_x0", xarray[0], tbl[i].x0);
            chk("tbl_x40", xarray[T-1], tbl[i].xl);
        end

        // STRIDE=4 instance: windows after samples 41, 45, 49 only
        step(0, 1, 0, 0, 1);
        for (int i = 1; i <= 49; i++) begin
            step(0, 0, 1, i, 1);
            chk("s4_out_valid", out_valid4, (i == 41) || (i == 45) || (i == 49));
            if (i == 41 || i == 45 || i == 49) begin
                chk("s4_x0", xarray4[0], i - 40);
                chk("s4_x40", xarray4[T-1], i);
            end
        end

        // Clear (mode 0) and reset (mode 1) dropping a simultaneous sample
        for (int mode = 0; mode < 2; mode++) begin
            step(0, 1, 0, 0, 1);
            for (int i = 1; i <= 20; i++) step(0, 0, 1, 100 + i, 1);
            step(mode == 1, mode == 0, 1, 999, 1);
            chk("drop_zero_taps", nonzero_taps(), 0);
            chk("drop_primed", primed, 0);
            chk("drop_out_valid", out_valid, 0);
            for (int i = 1; i <= T; i++) begin
                step(0, 0, 1, 200 + i, 1);
                chk("refill_valid", out_valid, i == T);
            end
            chk("refill_x0", xarray[0], 201);
            chk("refill_x40", xarray[T-1], 241);
            // Drop the presented window during a stall
            step(0, 0, 1, 7, 0);
            chk("stall_hold_x40", xarray[T-1], 241);
            step(mode == 1, mode == 0, 1, 8, 0);
            chk("stall_drop_valid", out_valid, 0);
            chk("stall_drop_taps", nonzero_taps(), 0);
        end

        // Random bubbles on both sides over 1000 accepted samples
        begin
            int acc_n = 0;
            for (int cyc = 0; cyc < 20000 && acc_n < 1000; cyc++) begin
                step(0, 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
                if (m_acc) acc_n++;
            end
            chk("bubble_budget", acc_n >= 1000, 1);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
            chk("bubble_drained", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feature_linebuffer.md
FEATURE_LINEBUFFER -- requirements
Module: feature_linebuffer

Interface
REQ-001 Parameter WIDTH, default 32, sample and tap bit width.
REQ-002 Parameter TAPS, default 41, window length (number of xarray entries).
REQ-003 Parameter STRIDE, default 1, accepted samples between successive windows after priming (legal range 1..TAPS).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 clear  input  1  synchronous flush of window contents and counters.
REQ-007 in_data  input  WIDTH  incoming feature sample.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block can accept a sample this cycle.
REQ-010 xarray  output  WIDTH x [0:TAPS-1]  registered window; index 0 is oldest, index TAPS-1 is newest.
REQ-011 out_valid  output  1  xarray holds a complete window for the downstream inner-product stage.
REQ-012 out_ready  input  1  downstream consumes the window this cycle.
REQ-013 primed  output  1  at least TAPS samples accepted since the last reset or clear.

Function
REQ-014 Accept: a sample is accepted when in_valid && in_ready are both high at a rising edge.
REQ-015 Ready rule: in_ready = !out_valid || out_ready, combinational; no other input gates in_ready.
REQ-016 Shift: on accept, xarray[k] <= xarray[k+1] for k = 0..TAPS-2, and xarray[TAPS-1] <= in_data, all in the same cycle.
REQ-017 Hold: without an accept, every xarray entry holds its value.
REQ-018 Fill counter: fill_cnt counts 0..TAPS, increments on accept, and saturates at TAPS; primed = (fill_cnt == TAPS).
REQ-019 Stride counter: stride_cnt counts 0..STRIDE-1 and runs only while primed or on the priming accept; it resets to 0 when a window is emitted.
REQ-020 Emit condition: an accept emits a window when it brings fill_cnt from TAPS-1 to TAPS, or when primed is already high and stride_cnt == STRIDE-1.
REQ-021 out_valid is set in the cycle after an emitting accept (latency 1), with xarray already holding the shifted window.
REQ-022 Clearing out_valid: out_valid falls after a cycle with out_ready high and no emitting accept.
REQ-023 Simultaneous consume and emit: out_ready high together with an emitting accept keeps out_valid high and presents the new window, giving 1 window per cycle at STRIDE=1.
REQ-024 Stall: while out_valid && !out_ready, in_ready is low, and xarray and all counters hold, so a presented window is never altered before it is consumed.
REQ-025 Non-emitting accepts while out_valid is high and out_ready is high consume the current window, so out_valid falls next cycle.
REQ-026 Clear: when clear is high, next cycle fill_cnt = 0, stride_cnt = 0, out_valid = 0, primed = 0, and xarray is all zero.
REQ-027 Clear priority: clear overrides a simultaneous accept, and that sample is discarded.
REQ-028 Arithmetic: counters use the minimum width (clog2(TAPS+1)); no arithmetic is done on data, and samples pass bit-exact.
REQ-029 xarray, out_valid and primed are driven only from registers, with no combinational path from in_data.

Reset
REQ-030 With rst high at a clock edge, next cycle xarray = all zero, out_valid = 0, primed = 0, and fill_cnt = stride_cnt = 0; in_ready is then 1.
REQ-031 rst has priority over clear and over any accept.
REQ-032 Reset mid-window, including during a stall, discards all contents; the next window needs TAPS fresh accepts.

Verification
REQ-033 Prime: stream 1,2,...,41 with in_valid high and out_ready high -> out_valid first high the cycle after sample 41, with xarray[0]=1 and xarray[40]=41; out_valid stays low before that.
REQ-034 Slide (STRIDE=1): continue with 42,43 -> out_valid high on consecutive cycles, with windows 2..42 then 3..43.
REQ-035 Stall: hold out_ready low for 5 cycles with window 1..41 presented -> in_ready = 0, xarray unchanged, out_valid held; the first cycle with out_ready high accepts the next sample.
REQ-036 Stride (STRIDE=4): stream 1..49 -> windows emitted after samples 41, 45 and 49 only, e.g. xarray[0]=5 and xarray[40]=45 for the second window.
REQ-037 Clear/reset: assert clear together with in_valid after 20 samples -> sample dropped, xarray zero, primed = 0; 41 more samples are then needed for out_valid; repeat the check with rst.
REQ-038 Bubbles: random in_valid (50%) and random out_ready (50%) over 1000 samples -> every emitted window equals the last 41 accepted samples in order, with no window lost or duplicated.
